// File: rtl/one_hot_decoder_pkg.sv
// Shared widths, types and the code-to-one-hot helper for the decoder slice.
package one_hot_decoder_pkg;

   localparam int CODE_W   = 3;
   localparam int ONEHOT_W = 8;

   typedef logic [CODE_W-1:0]   code_t;
   typedef logic [ONEHOT_W-1:0] onehot_t;

   // Single set bit at position c; every code 0..7 maps to a legal word.
   function automatic onehot_t code2onehot(input code_t c);
      return onehot_t'(1) << c;
   endfunction

endpackage

// File: rtl/one_hot_decoder_code_fifo.sv
// Circular queue of codes: storage, wrapping read/write pointers and occupancy.
import one_hot_decoder_pkg::*;

module code_fifo #(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  code_t            din,
   output code_t            head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   code_t            mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic             wr;
   logic             rd;

   // Ignore requests the queue cannot honour so occupancy stays in 0..DEPTH.
   assign wr    = push && !full;
   assign rd    = pop && !empty;
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign head  = mem[rptr];

   // Storage needs no reset: entries are only visible while counted.
   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= din;
   end

   // Pointers wrap naturally (DEPTH is a power of two); count tracks push-only/pop-only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr) wptr <= wptr + 1'b1;
         if (rd) rptr <= rptr + 1'b1;
         if (wr && !rd)      count <= count + 1'b1;
         else if (rd && !wr) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/one_hot_decoder.sv
// Queued binary-to-one-hot decoder with ready/valid on both sides and a sticky overflow flag.
import one_hot_decoder_pkg::*;

module one_hot_decoder #(
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  code_t            code,
   input  logic             in_valid,
   output logic             in_ready,
   output onehot_t          y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] count,
   output logic             ovf
);

   code_t head;
   logic  full;
   logic  empty;
   logic  push;
   logic  pop;

   // Ready/valid come from occupancy only, so out_ready never reaches in_ready.
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   code_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (code),
      .head  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // Decode the queue head; force zero when nothing is queued.
   assign y = out_valid ? code2onehot(head) : '0;

   // Overflow latches on any offer made while full and clears only on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       ovf <= 1'b0;
      else if (in_valid && !in_ready) ovf <= 1'b1;
   end

endmodule

// File: tb/tb_one_hot_decoder.sv
// Directed-vector bench for one_hot_decoder (DEPTH=4).
module tb_one_hot_decoder;
   import one_hot_decoder_pkg::*;

   logic       clk;
   logic       rst;
   code_t      code;
   logic       in_valid;
   logic       in_ready;
   onehot_t    y;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] count;
   logic       ovf;

   int nvec;
   int nerr;

   one_hot_decoder #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .code      (code),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle 1ns past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      nvec = 0;
      nerr = 0;
      rst = 1'b1; code = '0; in_valid = 1'b0; out_ready = 1'b0;

      // reset state
      #3;
      chk("rst_y", y, 8'h00);
      chk("rst_ov", out_valid, 0);
      chk("rst_cnt", count, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_irdy", in_ready, 1);
      #9 rst = 1'b0;  // t=12, between edges
      #4;             // t=16, just past an edge

      // single code 5
      code = 3'd5; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("one_y", y, 8'h20);
      chk("one_ov", out_valid, 1);
      chk("one_cnt", count, 1);
      step();
      chk("one_y0", y, 8'h00);
      chk("one_cnt0", count, 0);
      chk("one_ov0", out_valid, 0);

      // fill/drain three passes to exercise pointer wrap
      for (int p = 0; p < 3; p++) begin
         out_ready = 1'b0;
         for (int i = 0; i < 4; i++) begin
            code = code_t'(i); in_valid = 1'b1;
            step();
         end
         in_valid = 1'b0;
         chk("wrap_full_cnt", count, 4);
         chk("wrap_irdy", in_ready, 0);
         out_ready = 1'b1;
         for (int i = 0; i < 4; i++) begin
            chk("wrap_y", y, 32'h1 << i);
            step();
         end
         chk("wrap_empty", count, 0);
      end
      chk("wrap_ovf", ovf, 0);

      // backpressure on head 6, then full + simultaneous push/pop
      out_ready = 1'b0;
      code = 3'd6; in_valid = 1'b1; step();
      code = 3'd1; step();
      code = 3'd2; step();
      code = 3'd3; step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bp_y", y, 8'h40);
         chk("bp_ov", out_valid, 1);
         step();
      end
      code = 3'd7; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("full_irdy", in_ready, 0);
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      chk("full_cnt", count, 3);
      chk("full_ovf", ovf, 1);
      chk("full_y", y, 8'h02);
      out_ready = 1'b1;
      chk("drain_y1", y, 8'h02); step();
      chk("drain_y2", y, 8'h04); step();
      chk("drain_y3", y, 8'h08); step();
      chk("drain_cnt", count, 0);
      chk("drain_y0", y, 8'h00);
      chk("ovf_sticky", ovf, 1);

      // steady stream: one-cycle delay, occupancy constant at 1
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         code = code_t'(i);
         step();
         chk("strm_y", y, 32'h1 << i);
         chk("strm_cnt", count, 1);
      end
      in_valid = 1'b0;
      step();
      chk("strm_end", count, 0);

      // async reset mid-flight with three queued
      out_ready = 1'b0; in_valid = 1'b1;
      code = 3'd2; step();
      code = 3'd3; step();
      code = 3'd4; step();
      in_valid = 1'b0;
      chk("pre_rst_cnt", count, 3);
      #2 rst = 1'b1;
      #1;
      chk("arst_y", y, 8'h00);
      chk("arst_ov", out_valid, 0);
      chk("arst_cnt", count, 0);
      chk("arst_ovf", ovf, 0);
      chk("arst_irdy", in_ready, 1);
      #2 rst = 1'b0;

      // first push after reset release lands on the next edge
      code = 3'd4; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("post_y", y, 8'h10);
      chk("post_cnt", count, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
